cmplx_mac_pipe: RTL
===================

Name: cmplx_mac_pipe

Overview:
- Parametrised successor to the team's fixed 4-stage complex multiplier.
- Adds valid/last framing, a per-sample conjugate mode and a framed complex accumulator with guard bits and saturation.
- Sits between the sample datapath (a = signal, b = coefficient/reference) and downstream correlation/dot-product consumers.
- Emits one accumulated complex result per frame.

Parameters:
- AWIDTH, 16, signed width of ar/ai.
- BWIDTH, 18, signed width of br/bi.
- GUARD, 4, accumulator guard bits above the exact product-sum width.
- SATURATE, 1, 1 = clamp accumulator on overflow, 0 = two's-complement wrap (ovf still flagged).
- CNT_W, 16, width of the per-frame sample counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample qualifier
- in_last  in  1  final sample of frame; meaningful only with in_valid
- conj_b  in  1  1 = multiply by conj(b) for this sample; sampled with in_valid
- ar, ai  in  AWIDTH  signed operand a
- br, bi  in  BWIDTH  signed operand b
- out_valid  out  1  one-cycle pulse, frame result valid
- pr, pi  out  ACCW = AWIDTH+BWIDTH+1+GUARD  signed accumulated real/imag
- out_ovf  out  1  overflow occurred anywhere in the frame (sticky per frame)
- out_count  out  CNT_W  samples in the frame (wraps modulo 2^CNT_W)

Behaviour:
- Reset (async assert, registered release): all stage valid bits, accumulator, counter, sticky ovf and outputs go to 0. out_valid = 0.
- Reset mid-frame: the partial frame is discarded. The first valid sample after reset starts a new frame.
- No backpressure. A sample is accepted every cycle in_valid = 1. Gaps (in_valid = 0) are allowed anywhere, including mid-frame; the accumulator holds across gaps.
- Pipeline, for a sample accepted at edge t:
  - S1 (t+1): register ar, ai, br, bi, conj_b, last.
  - S2 (t+2): four products ar*br, ai*bi, ar*bi, ai*br, each AWIDTH+BWIDTH bits.
  - S3 (t+3): combine, sign-extended to AWIDTH+BWIDTH+1 (exact, no overflow possible).
    - Normal: re = ar*br - ai*bi, im = ar*bi + ai*br.
    - Conjugate: re = ar*br + ai*bi, im = ai*br - ar*bi.
  - S4 (t+4): accumulate.
- Accumulate rules:
  - If the accumulator is empty (frame start), sum = S3 value sign-extended to ACCW; otherwise sum = acc + S3 value.
  - The sum is computed at ACCW+1 bits. Overflow = the top two bits differ.
  - On overflow with SATURATE=1, clamp to +(2^(ACCW-1)-1) or -2^(ACCW-1) per sign. With SATURATE=0, keep the low ACCW bits.
  - Real and imaginary parts saturate independently. out_ovf is the OR of both, sticky within the frame.
- Frame end:
  - When the S3 sample has last = 1, the final sum goes to pr/pi, out_valid pulses at t+4, and out_count/out_ovf are presented.
  - In the same cycle the accumulator, count and sticky ovf are marked empty, so a sample from the next frame arriving in S3 the following cycle starts cleanly. Back-to-back frames, including 1-sample frames every cycle, need no bubbles.
- pr, pi, out_ovf and out_count hold their value until the next out_valid. They are registered outputs.
- conj_b is per sample, so mixed modes within one frame are legal.

Decomposition:
- Shared package cmplx_pkg holds:
  - ACCW derivation function.
  - Saturation limit constants/functions (sat_max(w), sat_min(w)).
  - Conjugate-mode encoding constant.
- One natural sub-module, cmplx_mult_core: stages S1–S3 (multiply and combine, valid/last/conj pipelined alongside). Reusable by non-accumulating users.
- The top level adds S4 accumulate/saturate/count.

Test Plan:
- Single 1-sample frame: a=(3,4), b=(5,-2), conj_b=0, last=1 at edge t -> out_valid at t+4 only; pr=23, pi=14, out_count=1, out_ovf=0.
- Same sample with conj_b=1 -> pr=7, pi=26.
- 3-sample frame with a gap cycle after sample 1, samples (1,0)(2,0), (0,1)(0,1), (2,2)(1,-1), normal mode -> single out_valid with pr=2-1+4=5, pi=0+0+0=0, count=3. No pulse before last.
- Back-to-back 1-sample frames over 8 consecutive cycles, a=(k,0), b=(1,0) -> out_valid high 8 consecutive cycles with pr=k, pi=0; no cross-frame leakage.
- Overflow, defaults (ACCW=39): 64 samples ar=-32768, ai=0, br=-131072, bi=0, last on sample 64 -> pr=274877906943, out_ovf=1, pi=0. With SATURATE=0 -> pr=-274877906944, out_ovf=1. A following 1-sample frame reports out_ovf=0.
- Assert rst asynchronously mid-frame (after 2 of 4 samples), release, then send a 1-sample frame a=(1,1), b=(1,1) -> no out_valid for the aborted frame; result pr=0, pi=2, count=1. All outputs read 0 immediately while rst is high.

Source files
------------

// File: rtl/cmplx_mac_pipe_pkg.sv
// Shared definitions for the complex multiply/accumulate pipeline:
// accumulator width derivation, saturation limits and conjugate-mode encoding.
package cmplx_pkg;

    localparam int SAT_WIDTH_MAX = 128;

    typedef enum logic {
        CONJ_OFF = 1'b0,
        CONJ_ON  = 1'b1
    } conj_mode_e;

    localparam conj_mode_e CONJ_MODE = CONJ_ON;

    function automatic int accw(input int aw, input int bw, input int guard);
        return aw + bw + 1 + guard;
    endfunction

    // Limits are built in a wide container; callers slice off the low w bits.
    function automatic logic [SAT_WIDTH_MAX-1:0] sat_max(input int w);
        logic [SAT_WIDTH_MAX-1:0] one;
        one = SAT_WIDTH_MAX'(1);
        return (one << (w - 1)) - one;
    endfunction

    function automatic logic [SAT_WIDTH_MAX-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/cmplx_mac_pipe_if.sv
// Sample-in / frame-result-out bundle for cmplx_mac_pipe.
interface cmplx_mac_pipe_if
    import cmplx_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 18,
    parameter int GUARD  = 4,
    parameter int CNT_W  = 16
);
    localparam int ACCW = accw(AWIDTH, BWIDTH, GUARD);

    logic                     in_valid;
    logic                     in_last;
    logic                     conj_b;
    logic signed [AWIDTH-1:0] ar;
    logic signed [AWIDTH-1:0] ai;
    logic signed [BWIDTH-1:0] br;
    logic signed [BWIDTH-1:0] bi;

    logic                     out_valid;
    logic signed [ACCW-1:0]   pr;
    logic signed [ACCW-1:0]   pi;
    logic                     out_ovf;
    logic [CNT_W-1:0]         out_count;

    modport master (
        output in_valid, in_last, conj_b, ar, ai, br, bi,
        input  out_valid, pr, pi, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_last, conj_b, ar, ai, br, bi,
        output out_valid, pr, pi, out_ovf, out_count
    );

endinterface

// File: rtl/cmplx_mac_pipe_mult_core.sv
// Three-stage complex multiplier (register, multiply, combine) with valid,
// last and per-sample conjugate mode travelling alongside the data.
module cmplx_mult_core
    import cmplx_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 18
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic                            conj_b,
    input  logic signed [AWIDTH-1:0]        ar,
    input  logic signed [AWIDTH-1:0]        ai,
    input  logic signed [BWIDTH-1:0]        br,
    input  logic signed [BWIDTH-1:0]        bi,
    output logic                            s3_valid,
    output logic                            s3_last,
    output logic signed [AWIDTH+BWIDTH:0]   re,
    output logic signed [AWIDTH+BWIDTH:0]   im
);
    localparam int PW = AWIDTH + BWIDTH;
    localparam int CW = PW + 1;

    logic                     s1_valid, s1_last;
    conj_mode_e               s1_mode;
    logic signed [AWIDTH-1:0] s1_ar, s1_ai;
    logic signed [BWIDTH-1:0] s1_br, s1_bi;

    logic                     s2_valid, s2_last;
    conj_mode_e               s2_mode;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= CONJ_OFF;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_br    <= '0;
            s1_bi    <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_last  <= in_last & in_valid;
            s1_mode  <= conj_mode_e'(conj_b);
            s1_ar    <= ar;
            s1_ai    <= ai;
            s1_br    <= br;
            s1_bi    <= bi;
        end
    end

    // Operands are sign-extended to the full product width before multiplying.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_mode  <= CONJ_OFF;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_mode  <= s1_mode;
            p_rr     <= PW'(s1_ar) * PW'(s1_br);
            p_ii     <= PW'(s1_ai) * PW'(s1_bi);
            p_ri     <= PW'(s1_ar) * PW'(s1_bi);
            p_ir     <= PW'(s1_ai) * PW'(s1_br);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            re       <= '0;
            im       <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            if (s2_mode == CONJ_MODE) begin
                re <= CW'(p_rr) + CW'(p_ii);
                im <= CW'(p_ir) - CW'(p_ri);
            end else begin
                re <= CW'(p_rr) - CW'(p_ii);
                im <= CW'(p_ri) + CW'(p_ir);
            end
        end
    end

endmodule

// File: rtl/cmplx_mac_pipe.sv
// Framed complex multiply-accumulate: multiplier core plus an accumulate stage
// with guard bits, optional saturation, sticky overflow and a sample counter.
module cmplx_mac_pipe
    import cmplx_pkg::*;
#(
    parameter int AWIDTH   = 16,
    parameter int BWIDTH   = 18,
    parameter int GUARD    = 4,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
)(
    input  logic             clk,
    input  logic             rst,
    cmplx_mac_pipe_if.slave  bus
);
    localparam int CW   = AWIDTH + BWIDTH + 1;
    localparam int ACCW = accw(AWIDTH, BWIDTH, GUARD);
    localparam int SW   = ACCW + 1;

    localparam logic [SAT_WIDTH_MAX-1:0] HI_FULL = sat_max(ACCW);
    localparam logic [SAT_WIDTH_MAX-1:0] LO_FULL = sat_min(ACCW);
    localparam logic signed [ACCW-1:0]   SAT_HI  = HI_FULL[ACCW-1:0];
    localparam logic signed [ACCW-1:0]   SAT_LO  = LO_FULL[ACCW-1:0];

    logic                   s3_valid, s3_last;
    logic signed [CW-1:0]   s3_re, s3_im;

    logic                   acc_active;
    logic signed [ACCW-1:0] acc_re, acc_im;
    logic [CNT_W-1:0]       acc_count;
    logic                   acc_ovf;

    logic signed [ACCW-1:0] base_re, base_im;
    logic signed [SW-1:0]   sum_re, sum_im;
    logic                   ovf_re, ovf_im;
    logic signed [ACCW-1:0] new_re, new_im;
    logic [CNT_W-1:0]       new_count;
    logic                   new_ovf;

    logic                   res_valid;
    logic signed [ACCW-1:0] res_re, res_im;
    logic                   res_ovf;
    logic [CNT_W-1:0]       res_count;

    cmplx_mult_core #(
        .AWIDTH (AWIDTH),
        .BWIDTH (BWIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_last  (bus.in_last),
        .conj_b   (bus.conj_b),
        .ar       (bus.ar),
        .ai       (bus.ai),
        .br       (bus.br),
        .bi       (bus.bi),
        .s3_valid (s3_valid),
        .s3_last  (s3_last),
        .re       (s3_re),
        .im       (s3_im)
    );

    // Overflow shows as disagreement between the two top bits of the wide sum.
    function automatic logic signed [ACCW-1:0] clamp(input logic signed [SW-1:0] s);
        if (SATURATE != 0 && (s[SW-1] != s[SW-2]))
            return s[SW-1] ? SAT_LO : SAT_HI;
        return s[ACCW-1:0];
    endfunction

    always_comb begin
        base_re   = acc_active ? acc_re : '0;
        base_im   = acc_active ? acc_im : '0;
        sum_re    = SW'(base_re) + SW'(s3_re);
        sum_im    = SW'(base_im) + SW'(s3_im);
        ovf_re    = sum_re[SW-1] ^ sum_re[SW-2];
        ovf_im    = sum_im[SW-1] ^ sum_im[SW-2];
        new_re    = clamp(sum_re);
        new_im    = clamp(sum_im);
        new_count = (acc_active ? acc_count : '0) + CNT_W'(1);
        new_ovf   = (acc_active & acc_ovf) | ovf_re | ovf_im;
    end

    // A last sample publishes the result and empties the accumulator in the
    // same cycle, so the next frame can enter S3 immediately behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_active <= 1'b0;
            acc_re     <= '0;
            acc_im     <= '0;
            acc_count  <= '0;
            acc_ovf    <= 1'b0;
            res_valid  <= 1'b0;
            res_re     <= '0;
            res_im     <= '0;
            res_ovf    <= 1'b0;
            res_count  <= '0;
        end else begin
            res_valid <= 1'b0;
            if (s3_valid) begin
                if (s3_last) begin
                    res_valid  <= 1'b1;
                    res_re     <= new_re;
                    res_im     <= new_im;
                    res_ovf    <= new_ovf;
                    res_count  <= new_count;
                    acc_active <= 1'b0;
                    acc_re     <= '0;
                    acc_im     <= '0;
                    acc_count  <= '0;
                    acc_ovf    <= 1'b0;
                end else begin
                    acc_active <= 1'b1;
                    acc_re     <= new_re;
                    acc_im     <= new_im;
                    acc_count  <= new_count;
                    acc_ovf    <= new_ovf;
                end
            end
        end
    end

    assign bus.out_valid = res_valid;
    assign bus.pr        = res_re;
    assign bus.pi        = res_im;
    assign bus.out_ovf   = res_ovf;
    assign bus.out_count = res_count;

endmodule
